// File: rtl/imm_pkg.sv
// Shared immediate-encoding definitions for the sign-extend and compress units.
package imm_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_IMM_DATA_WIDTH = 7;

    // Signed range of a default-width immediate (-64..+63).
    localparam int IMM_MAX = (2 ** (DEF_IMM_DATA_WIDTH - 1)) - 1;
    localparam int IMM_MIN = -(2 ** (DEF_IMM_DATA_WIDTH - 1));

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } buf_state_t;

endpackage

// File: rtl/imm_range_check.sv
// Combinational range check and narrowing of an operand to a signed immediate.
// IMM_COMPRESS_SATURATE_EN selects clamping of out-of-range operands instead of wrapping.
module imm_range_check
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int IMM_DATA_WIDTH = DEF_IMM_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]     data_in,
    output logic                      fits,
    output logic                      sign,
    output logic [IMM_DATA_WIDTH-1:0] imm
);

    logic [DATA_WIDTH-IMM_DATA_WIDTH:0] upper;

    // The value fits only when the immediate's sign bit and everything above it agree.
    assign upper = data_in[DATA_WIDTH-1:IMM_DATA_WIDTH-1];
    assign fits  = (&upper) | ~(|upper);
    assign sign  = data_in[DATA_WIDTH-1];

`ifdef IMM_COMPRESS_SATURATE_EN
    always_comb begin
        if (fits)
            imm = data_in[IMM_DATA_WIDTH-1:0];
        else if (sign)
            imm = {1'b1, {(IMM_DATA_WIDTH-1){1'b0}}};
        else
            imm = {1'b0, {(IMM_DATA_WIDTH-1){1'b1}}};
    end
`else
    assign imm = data_in[IMM_DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/imm_compress.sv
// Streaming operand-to-immediate compressor with a 2-entry output buffer and overflow counter.
// Define IMM_COMPRESS_SATURATE_EN to clamp out-of-range operands instead of truncating them.
module imm_compress
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int IMM_DATA_WIDTH = DEF_IMM_DATA_WIDTH,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [IMM_DATA_WIDTH-1:0] imm_out,
    output logic                      ovf_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      ovf_clr,
    output logic [CNT_WIDTH-1:0]      ovf_count
);

    typedef struct packed {
        logic                      ovf;
        logic [IMM_DATA_WIDTH-1:0] imm;
    } entry_t;

    buf_state_t                state_q, state_d;
    entry_t                    head_q, tail_q, new_entry;
    logic                      fits, range_sign_unused;
    logic [IMM_DATA_WIDTH-1:0] narrowed;
    logic                      push, pop;
    logic                      load_head, load_tail, head_from_tail;
    logic [CNT_WIDTH-1:0]      ovf_count_q;

    imm_range_check #(
        .DATA_WIDTH     (DATA_WIDTH),
        .IMM_DATA_WIDTH (IMM_DATA_WIDTH)
    ) u_range_check (
        .data_in (data_in),
        .fits    (fits),
        .sign    (range_sign_unused),
        .imm     (narrowed)
    );

    assign new_entry = '{ovf: ~fits, imm: narrowed};

    // Handshake is decoded from registered occupancy only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_head      = 1'b0;
        load_tail      = 1'b0;
        head_from_tail = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    // NOTE: the buffer entries are reset because the head drives imm_out/ovf_out directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head)
                head_q <= new_entry;
            else if (head_from_tail)
                head_q <= tail_q;
            if (load_tail)
                tail_q <= new_entry;
        end
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_count_q <= '0;
        else if (ovf_clr)
            ovf_count_q <= '0;
        else if (push && !fits && (ovf_count_q != {CNT_WIDTH{1'b1}}))
            ovf_count_q <= ovf_count_q + 1'b1;
    end

    assign imm_out   = head_q.imm;
    assign ovf_out   = head_q.ovf;
    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_imm_compress.sv
// Self-checking bench for imm_compress against a queue-based reference model.
module tb_imm_compress;
    import imm_pkg::*;

    localparam int DW      = 16;
    localparam int IW      = 7;
    localparam int CW      = 8;
    localparam int CNT_MAX = (2 ** CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] imm_out;
    logic          ovf_out;
    logic          out_valid;
    logic          out_ready;
    logic          ovf_clr;
    logic [CW-1:0] ovf_count;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] imm;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    int   model_cnt = 0;
    int   n_asserts = 0;
    int   n_fail    = 0;

    imm_compress #(
        .DATA_WIDTH     (DW),
        .IMM_DATA_WIDTH (IW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_out   (imm_out),
        .ovf_out   (ovf_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: range from signed integer comparison, result from the encoding rule.
    function automatic exp_t ref_model(input logic [DW-1:0] d);
        exp_t e;
        int   v;
        v      = int'($signed(d));
        e.data = d;
        e.ovf  = (v < IMM_MIN) || (v > IMM_MAX);
        if (!e.ovf)
            e.imm = d[IW-1:0];
        else begin
`ifdef IMM_COMPRESS_SATURATE_EN
            e.imm = (v > 0) ? IW'(IMM_MAX) : IW'(IMM_MIN);
`else
            e.imm = d[IW-1:0];
`endif
        end
        return e;
    endfunction

    // One clock: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy, input logic clr);
        logic push, pop;
        int   sx, dv;
        in_valid  = v;
        data_in   = d;
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() != 0);
        check("ovf_count", ovf_count, model_cnt);
        if (q.size() != 0) begin
            check("imm_out", imm_out, q[0].imm);
            check("ovf_out", ovf_out, q[0].ovf);
            if (!q[0].ovf) begin
                sx = int'($signed(imm_out));
                dv = int'($signed(q[0].data));
                check("sext_roundtrip", sx, dv);
            end
        end
        push = v && (q.size() < 2);
        pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (pop)
            void'(q.pop_front());
        if (push)
            q.push_back(ref_model(d));
        if (clr)
            model_cnt = 0;
        else if (push && ref_model(d).ovf && model_cnt < CNT_MAX)
            model_cnt++;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] rd;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm_out", imm_out, 0);
        check("rst_ovf_out", ovf_out, 0);
        check("rst_ovf_count", ovf_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed range boundaries and both overflow directions.
        step(1'b1, 16'h0005, 1'b1, 1'b0);
        step(1'b1, 16'hFFC0, 1'b1, 1'b0);
        step(1'b1, 16'h003F, 1'b1, 1'b0);
        step(1'b1, 16'h0040, 1'b1, 1'b0);
        step(1'b1, 16'hFF00, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ovf_count_two", ovf_count, 2);

        // Backpressure: third word held until space frees up.
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b0, 1'b0);
        step(1'b1, 16'h0003, 1'b1, 1'b0);
        step(1'b1, 16'h0003, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset while full.
        step(1'b1, 16'h0070, 1'b0, 1'b0);
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("full_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_ovf_count", ovf_count, 0);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Random traffic, biased toward the range boundary.
        for (int i = 0; i < 250; i++) begin
            rd = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 255)) - DW'(128)
                                              : DW'($urandom);
            step(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        end
        for (int i = 0; i < 3; i++)
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b1);

        // Counter saturation, then clear racing a non-fit push.
        for (int i = 0; i < 300; i++)
            step(1'b1, 16'h1000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ovf_count_sat", ovf_count, CNT_MAX);
        step(1'b1, 16'h4000, 1'b1, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        check("ovf_count_clr", ovf_count, 0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
